// File: rtl/bwt_occ_responder.sv
// Responder for backward-control occurrence fetches: queues {k,l} requests, issues in-order
// cacheline reads, pairs the returned k/l lines and emits them tagged with read_num.
module bwt_occ_responder #(
  parameter int unsigned CL_W         = 512,
  parameter int unsigned ADDR_W       = 42,
  parameter int unsigned TAG_W        = 10,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_valid,
  input  logic [ADDR_W-1:0] addr_k,
  input  logic [ADDR_W-1:0] addr_l,
  input  logic [TAG_W-1:0]  read_num,
  output logic              stall,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [CL_W-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  output logic [TAG_W-1:0]  rsp_read_num,
  output logic [CL_W-1:0]   rsp_cl_k,
  output logic [CL_W-1:0]   rsp_cl_l,
  output logic [1:0]        err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] l;
    logic              same;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             same;
  } tag_t;

  typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} issue_state_t;
  typedef enum logic {WAIT_K, WAIT_L} rsp_state_t;

  issue_state_t state, state_nxt;
  rsp_state_t   rstate, rstate_nxt;

  req_t             req_mem [DEPTH];
  tag_t             tag_mem [DEPTH];
  logic [PTR_W-1:0] req_wr_ptr, req_rd_ptr, req_rd_ptr_nxt;
  logic [PTR_W-1:0] tag_wr_ptr, tag_rd_ptr;
  logic [CNT_W-1:0] req_count, req_count_nxt, tag_count, tag_count_nxt;

  logic [ADDR_W-1:0] cur_l, cur_l_nxt;
  logic [TAG_W-1:0]  cur_tag, cur_tag_nxt;
  logic              cur_same, cur_same_nxt;

  req_t req_in, head_nxt;
  tag_t tag_in, tag_head;
  logic mem_hs, final_hs, req_push, req_pop, tag_push, tag_pop, start, drop, orphan;
  logic              mem_req_valid_nxt;
  logic [ADDR_W-1:0] mem_req_addr_nxt;
  logic              rsp_valid_nxt;
  logic [TAG_W-1:0]  rsp_read_num_nxt;
  logic [CL_W-1:0]   rsp_cl_k_nxt, rsp_cl_l_nxt;

  // Issue side: the next pair may start from IDLE or straight after the final handshake,
  // taking its head from the FIFO or, when the FIFO is about to be empty, from the input.
  always_comb begin
    req_in         = '{tag: read_num, k: addr_k, l: addr_l, same: (addr_k == addr_l)};
    tag_in         = '{tag: cur_tag, same: cur_same};
    mem_hs         = mem_req_valid & mem_req_ready;
    final_hs       = mem_hs & ((state == ISSUE_L) | ((state == ISSUE_K) & cur_same));
    req_pop        = final_hs;
    req_push       = request_valid & ((req_count != FULL_CNT) | req_pop);
    drop           = request_valid & ~req_push;
    req_count_nxt  = req_count + CNT_W'(req_push) - CNT_W'(req_pop);
    req_rd_ptr_nxt = req_rd_ptr + PTR_W'(req_pop);
    head_nxt       = ((req_count == CNT_W'(req_pop)) & req_push) ? req_in : req_mem[req_rd_ptr_nxt];
    tag_push       = final_hs;
    tag_count_nxt  = tag_count + CNT_W'(tag_push) - CNT_W'(tag_pop);
    start          = ((state == IDLE) | final_hs) & (req_count_nxt != '0) & (tag_count_nxt != FULL_CNT);

    state_nxt         = state;
    mem_req_valid_nxt = mem_req_valid;
    mem_req_addr_nxt  = mem_req_addr;
    cur_l_nxt         = cur_l;
    cur_tag_nxt       = cur_tag;
    cur_same_nxt      = cur_same;
    if (start) begin
      state_nxt         = ISSUE_K;
      mem_req_valid_nxt = 1'b1;
      mem_req_addr_nxt  = head_nxt.k;
      cur_l_nxt         = head_nxt.l;
      cur_tag_nxt       = head_nxt.tag;
      cur_same_nxt      = head_nxt.same;
    end else if (final_hs) begin
      state_nxt         = IDLE;
      mem_req_valid_nxt = 1'b0;
    end else if (mem_hs) begin
      state_nxt        = ISSUE_L;
      mem_req_addr_nxt = cur_l;
    end
  end

  // Response side: pair in-order beats against the head of the in-flight tag FIFO.
  always_comb begin
    tag_head         = tag_mem[tag_rd_ptr];
    rstate_nxt       = rstate;
    tag_pop          = 1'b0;
    orphan           = 1'b0;
    rsp_valid_nxt    = 1'b0;
    rsp_read_num_nxt = rsp_read_num;
    rsp_cl_k_nxt     = rsp_cl_k;
    rsp_cl_l_nxt     = rsp_cl_l;
    if (mem_rsp_valid) begin
      if (rstate == WAIT_L) begin
        rsp_cl_l_nxt     = mem_rsp_data;
        tag_pop          = 1'b1;
        rsp_valid_nxt    = 1'b1;
        rsp_read_num_nxt = tag_head.tag;
        rstate_nxt       = WAIT_K;
      end else if (tag_count == '0) begin
        orphan = 1'b1;
      end else begin
        rsp_cl_k_nxt = mem_rsp_data;
        if (tag_head.same) begin
          rsp_cl_l_nxt     = mem_rsp_data;
          tag_pop          = 1'b1;
          rsp_valid_nxt    = 1'b1;
          rsp_read_num_nxt = tag_head.tag;
        end else begin
          rstate_nxt = WAIT_L;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rstate        <= WAIT_K;
      req_wr_ptr    <= '0;
      req_rd_ptr    <= '0;
      req_count     <= '0;
      tag_wr_ptr    <= '0;
      tag_rd_ptr    <= '0;
      tag_count     <= '0;
      cur_l         <= '0;
      cur_tag       <= '0;
      cur_same      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      stall         <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_read_num  <= '0;
      rsp_cl_k      <= '0;
      rsp_cl_l      <= '0;
      err           <= '0;
    end else begin
      state         <= state_nxt;
      rstate        <= rstate_nxt;
      req_wr_ptr    <= req_wr_ptr + PTR_W'(req_push);
      req_rd_ptr    <= req_rd_ptr_nxt;
      req_count     <= req_count_nxt;
      tag_wr_ptr    <= tag_wr_ptr + PTR_W'(tag_push);
      tag_rd_ptr    <= tag_rd_ptr + PTR_W'(tag_pop);
      tag_count     <= tag_count_nxt;
      cur_l         <= cur_l_nxt;
      cur_tag       <= cur_tag_nxt;
      cur_same      <= cur_same_nxt;
      mem_req_valid <= mem_req_valid_nxt;
      mem_req_addr  <= mem_req_addr_nxt;
      stall         <= (req_count >= AFULL_CNT);
      rsp_valid     <= rsp_valid_nxt;
      rsp_read_num  <= rsp_read_num_nxt;
      rsp_cl_k      <= rsp_cl_k_nxt;
      rsp_cl_l      <= rsp_cl_l_nxt;
      err           <= err | {orphan, drop};
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_ptr] <= req_in;
    if (tag_push) tag_mem[tag_wr_ptr] <= tag_in;
  end

endmodule

// File: tb/tb_bwt_occ_responder.sv
// Scoreboard bench for bwt_occ_responder with an in-order memory model.
module tb_bwt_occ_responder;

  localparam int CL_W   = 512;
  localparam int ADDR_W = 42;
  localparam int TAG_W  = 10;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [CL_W-1:0]  k;
    logic [CL_W-1:0]  l;
  } exp_t;

  typedef struct {
    int              due;
    logic [CL_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              request_valid = 1'b0;
  logic [ADDR_W-1:0] addr_k = '0;
  logic [ADDR_W-1:0] addr_l = '0;
  logic [TAG_W-1:0]  read_num = '0;
  logic              stall;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready = 1'b0;
  logic              mem_rsp_valid = 1'b0;
  logic [CL_W-1:0]   mem_rsp_data = '0;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_read_num;
  logic [CL_W-1:0]   rsp_cl_k;
  logic [CL_W-1:0]   rsp_cl_l;
  logic [1:0]        err;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  beat_t             pend_q[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rsp_seen = 0;
  int   beat_cyc = 0;
  int   last_due = 0;
  int   mem_lat = 3;
  bit   lat_rand = 1'b0;
  bit   ready_rand = 1'b0;
  logic ready_cfg = 1'b0;
  logic prev_stuck = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  bwt_occ_responder dut (
    .clk(clk), .rst(rst), .request_valid(request_valid), .addr_k(addr_k), .addr_l(addr_l),
    .read_num(read_num), .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_read_num(rsp_read_num), .rsp_cl_k(rsp_cl_k), .rsp_cl_l(rsp_cl_l),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CL_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [CL_W-1:0] r;
    for (int i = 0; i < CL_W / 32; i++) r[i*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * 32'(i + 1));
    return r;
  endfunction

  task automatic check(input string name, input logic [CL_W-1:0] got, input logic [CL_W-1:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    else n_pass++;
  endtask

  // Output checks, memory model and ready driving, all away from the active edge.
  always @(negedge clk) begin
    exp_t              e;
    beat_t             b;
    logic [ADDR_W-1:0] a;
    int                lat;
    int                due;
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) check("rsp_unexpected", CL_W'(1), CL_W'(0));
      else begin
        e = exp_q.pop_front();
        check("rsp_tag", CL_W'(rsp_read_num), CL_W'(e.tag));
        check("rsp_cl_k", rsp_cl_k, e.k);
        check("rsp_cl_l", rsp_cl_l, e.l);
        check("rsp_latency", CL_W'(cyc), CL_W'(beat_cyc + 1));
      end
    end
    if (prev_stuck) begin
      check("req_valid_hold", CL_W'(mem_req_valid), CL_W'(1));
      check("req_addr_hold", CL_W'(mem_req_addr), CL_W'(prev_addr));
    end
    mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_cfg;
    prev_stuck    = mem_req_valid && !mem_req_ready && !rst;
    prev_addr     = mem_req_addr;
    if (mem_req_valid && mem_req_ready && !rst) begin
      if (addr_q.size() == 0) check("req_unexpected", CL_W'(1), CL_W'(0));
      else begin
        a = addr_q.pop_front();
        check("req_addr", CL_W'(mem_req_addr), CL_W'(a));
      end
      lat = lat_rand ? int'($urandom_range(1, 6)) : mem_lat;
      due = cyc + 1 + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      b.due  = due;
      b.data = line_of(mem_req_addr);
      pend_q.push_back(b);
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      b = pend_q.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = b.data;
      beat_cyc      = cyc;
    end else begin
      mem_rsp_valid = 1'b0;
    end
  end

  // Drive one request for one cycle; call just after a rising edge.
  task automatic send(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l,
                      input logic [TAG_W-1:0] t, input bit accept);
    exp_t e;
    request_valid = 1'b1;
    addr_k        = k;
    addr_l        = l;
    read_num      = t;
    if (accept) begin
      addr_q.push_back(k);
      if (k != l) addr_q.push_back(l);
      e.tag = t;
      e.k   = line_of(k);
      e.l   = line_of(l);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    request_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    request_valid = 1'b0;
    exp_q.delete();
    addr_q.delete();
    pend_q.delete();
    last_due = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, CL_W'(exp_q.size() + addr_q.size()), CL_W'(0));
    idle(2);
  endtask

  task automatic check_zero(input string name);
    check({name, "_stall"}, CL_W'(stall), CL_W'(0));
    check({name, "_req_valid"}, CL_W'(mem_req_valid), CL_W'(0));
    check({name, "_req_addr"}, CL_W'(mem_req_addr), CL_W'(0));
    check({name, "_rsp_valid"}, CL_W'(rsp_valid), CL_W'(0));
    check({name, "_rsp_tag"}, CL_W'(rsp_read_num), CL_W'(0));
    check({name, "_rsp_cl_k"}, rsp_cl_k, CL_W'(0));
    check({name, "_rsp_cl_l"}, rsp_cl_l, CL_W'(0));
    check({name, "_err"}, CL_W'(err), CL_W'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen0;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] l;
    beat_t b;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    // Distinct k/l pair, then a shared-line pair fetched once.
    ready_cfg = 1'b1;
    send(42'h100, 42'h200, 10'd5, 1'b1);
    wait_drain("t1_drain");
    send(42'h300, 42'h300, 10'd7, 1'b1);
    wait_drain("t2_drain");
    @(negedge clk);
    check("t2_hold_k", rsp_cl_k, line_of(42'h300));
    check("t2_hold_l", rsp_cl_l, line_of(42'h300));
    check("t2_err", CL_W'(err), CL_W'(0));
    @(posedge clk); #1;

    // Random pairs under random ready and random return gaps.
    ready_rand = 1'b1;
    lat_rand   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k = ADDR_W'({$urandom, $urandom});
      l = (i % 3 == 0) ? k : ADDR_W'({$urandom, $urandom});
      send(k, l, TAG_W'(i), 1'b1);
      idle(int'($urandom_range(0, 2)));
    end
    wait_drain("t4_drain");
    ready_rand = 1'b0;
    lat_rand   = 1'b0;
    @(negedge clk);
    check("t4_err", CL_W'(err), CL_W'(0));
    @(posedge clk); #1;

    // Stall threshold and overflow drop with memory blocked.
    do_reset();
    ready_cfg = 1'b0;
    for (int i = 0; i < 11; i++) send(ADDR_W'(32'h1000 + i), ADDR_W'(32'h2000 + i), TAG_W'(i), 1'b0);
    idle(1);
    @(negedge clk);
    check("t3_stall_at11", CL_W'(stall), CL_W'(0));
    @(posedge clk); #1;
    send(42'h100b, 42'h200b, 10'd11, 1'b0);
    @(negedge clk);
    check("t3_stall_reg_delay", CL_W'(stall), CL_W'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_stall_at12", CL_W'(stall), CL_W'(1));
    @(posedge clk); #1;
    for (int i = 12; i < 16; i++) send(ADDR_W'(32'h1000 + i), ADDR_W'(32'h2000 + i), TAG_W'(i), 1'b0);
    @(negedge clk);
    check("t3_err_at16", CL_W'(err), CL_W'(0));
    @(posedge clk); #1;
    send(42'h1010, 42'h2010, 10'd16, 1'b0);
    @(negedge clk);
    check("t3_drop_err", CL_W'(err), CL_W'(1));
    @(posedge clk); #1;

    // Push and pop together at full, then prove the FIFO is still full.
    do_reset();
    ready_cfg = 1'b0;
    for (int i = 0; i < 16; i++) send(ADDR_W'(32'h5000 + i), ADDR_W'(32'h5000 + i), TAG_W'(20 + i), 1'b1);
    @(negedge clk);
    check("t6_full_stall", CL_W'(stall), CL_W'(1));
    @(posedge clk); #1;
    ready_cfg = 1'b1;
    send(42'h6000, 42'h6000, 10'd40, 1'b1);
    ready_cfg = 1'b0;
    @(negedge clk);
    check("t6_no_drop", CL_W'(err), CL_W'(0));
    @(posedge clk); #1;
    send(42'h7000, 42'h7001, 10'd41, 1'b0);
    @(negedge clk);
    check("t6_count_full", CL_W'(err), CL_W'(1));
    @(posedge clk); #1;
    ready_cfg = 1'b1;
    wait_drain("t6_drain");

    // Reset with pairs in flight; the stale beats must be flagged, not delivered.
    do_reset();
    ready_cfg = 1'b1;
    mem_lat   = 30;
    send(42'h800, 42'h900, 10'd50, 1'b1);
    send(42'h801, 42'h901, 10'd51, 1'b1);
    send(42'h802, 42'h902, 10'd52, 1'b1);
    idle(10);
    check("t5_all_issued", CL_W'(addr_q.size()), CL_W'(0));
    do_reset();
    @(negedge clk);
    check_zero("t5_reset");
    @(posedge clk); #1;
    seen0 = rsp_seen;
    b.due = 0;
    b.data = line_of(42'h800);
    pend_q.push_back(b);
    b.data = line_of(42'h900);
    pend_q.push_back(b);
    idle(10);
    @(negedge clk);
    check("t5_orphan_err", CL_W'(err), CL_W'(2));
    check("t5_no_rsp", CL_W'(rsp_seen - seen0), CL_W'(0));
    mem_lat = 3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
